ila_trigger_ctrl: RTL



---
 rtl/ila_trigger_ctrl_pkg.sv | 26 ++
 rtl/ila_trig_timer.sv | 33 +++
 rtl/ila_trigger_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/ila_trigger_ctrl_pkg.sv
// Shared RVVI debug types: the ILA trigger controller state encoding,
// default timing constants and a small sizing helper used for the
// shared timer width.
package ila_trigger_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_DISARMED,
    ST_ARMED,
    ST_FIRE,
    ST_WAIT_ACK,
    ST_HOLDOFF
  } ila_trig_state_t;

  localparam int unsigned ILA_PULSE_LEN_DEF   = 10;
  localparam int unsigned ILA_HOLDOFF_DEF     = 64;
  localparam int unsigned ILA_ACK_TIMEOUT_DEF = 1024;

  function automatic int unsigned ila_max3(input int unsigned a,
                                           input int unsigned b,
                                           input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ila_trig_timer.sv
// Shared phase timer for the ILA trigger controller.
// Ports:
//   clk, rst  - clock, async active-high reset
//   clr_i     - zero the count (state entry)
//   en_i      - count up this cycle
//   last_i    - terminal value for the current phase
//   done_o    - count equals last_i (final cycle of the phase)
module ila_trig_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] last_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign done_o = (cnt_q == last_i);

endmodule

// File: rtl/ila_trigger_ctrl.sv
// ILA trigger controller: arms at a frame boundary on software request,
// turns a scanner match pulse into a stretched ILA trigger, optionally
// waits for an ILA acknowledge, then holds off before re-arming.
// Ports:
//   clk, reset          - clock, async active-high reset
//   RvviAxiRvalid/Rlast - receive beat tracking (frame boundary)
//   TriggerMatch        - one-cycle match from frame scanner
//   ArmEn               - software arm level
//   IlaTriggerAck       - one-cycle ILA acknowledge
//   ClearStatus         - clear counters and AckTimeout
//   IlaTrigger, Armed   - registered state decodes
//   FireCount/MissCount - trigger statistics (wrap / saturate)
//   AckTimeout          - sticky acknowledge timeout flag
module ila_trigger_ctrl
  import ila_trigger_ctrl_pkg::*;
#(
  parameter int unsigned PULSE_LEN   = ILA_PULSE_LEN_DEF,
  parameter int unsigned HOLDOFF     = ILA_HOLDOFF_DEF,
  parameter int unsigned ACK_REQ     = 0,
  parameter int unsigned ACK_TIMEOUT = ILA_ACK_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RvviAxiRvalid,
  input  logic        RvviAxiRlast,
  input  logic        TriggerMatch,
  input  logic        ArmEn,
  input  logic        IlaTriggerAck,
  input  logic        ClearStatus,
  output logic        IlaTrigger,
  output logic        Armed,
  output logic [15:0] FireCount,
  output logic [7:0]  MissCount,
  output logic        AckTimeout
);

  localparam int unsigned TMAX = ila_max3(PULSE_LEN, HOLDOFF, ACK_TIMEOUT);
  localparam int unsigned TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] PULSE_LAST = TW'(PULSE_LEN - 1);
  localparam logic [TW-1:0] ACK_LAST   = TW'(ACK_TIMEOUT - 1);
  localparam logic [TW-1:0] HOLD_LAST  = TW'((HOLDOFF == 0) ? 0 : HOLDOFF - 1);

  ila_trig_state_t state_q, state_d, post_fire;
  logic            in_frame_q, in_frame_d;
  logic            ack_seen_q;
  logic            trig_q, armed_q;
  logic [15:0]     fire_cnt_q;
  logic [7:0]      miss_cnt_q;
  logic            ack_to_q;
  logic            arm_ok, fire_now, miss_now, set_timeout;
  logic            timer_clr, timer_en, timer_done;
  logic [TW-1:0]   timer_last;

  always_comb begin
    // Arming looks at the frame state after this beat, so an Rlast beat
    // arms on the same edge.
    in_frame_d = in_frame_q;
    if (RvviAxiRvalid) in_frame_d = ~RvviAxiRlast;
    arm_ok = ArmEn & ~in_frame_d;

    // With no hold-off the trigger phase exits straight to re-arm decision.
    if (HOLDOFF == 0) post_fire = arm_ok ? ST_ARMED : ST_DISARMED;
    else              post_fire = ST_HOLDOFF;

    case (state_q)
      ST_FIRE:     timer_last = PULSE_LAST;
      ST_WAIT_ACK: timer_last = ACK_LAST;
      default:     timer_last = HOLD_LAST;
    endcase

    state_d     = state_q;
    fire_now    = 1'b0;
    set_timeout = 1'b0;
    case (state_q)
      ST_DISARMED: if (arm_ok) state_d = ST_ARMED;
      ST_ARMED: begin
        if (TriggerMatch) begin
          fire_now = 1'b1;
          state_d  = ST_FIRE;
        end else if (!ArmEn) begin
          state_d = ST_DISARMED;
        end
      end
      ST_FIRE: begin
        if (timer_done) begin
          if (ACK_REQ == 0 || ack_seen_q || IlaTriggerAck) state_d = post_fire;
          else                                              state_d = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (IlaTriggerAck) begin
          state_d = post_fire;
        end else if (timer_done) begin
          state_d     = post_fire;
          set_timeout = 1'b1;
        end
      end
      ST_HOLDOFF: if (timer_done) state_d = arm_ok ? ST_ARMED : ST_DISARMED;
      default:    state_d = ST_DISARMED;
    endcase

    miss_now  = TriggerMatch & (state_q != ST_ARMED);
    timer_clr = (state_d != state_q);
    timer_en  = state_q inside {ST_FIRE, ST_WAIT_ACK, ST_HOLDOFF};
  end

  ila_trig_timer #(.W(TW)) u_timer (
    .clk    (clk),
    .rst    (reset),
    .clr_i  (timer_clr),
    .en_i   (timer_en),
    .last_i (timer_last),
    .done_o (timer_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_DISARMED;
      in_frame_q <= 1'b0;
      ack_seen_q <= 1'b0;
      trig_q     <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_frame_q <= in_frame_d;
      if (fire_now)                                 ack_seen_q <= 1'b0;
      else if (state_q == ST_FIRE && IlaTriggerAck) ack_seen_q <= 1'b1;
      trig_q     <= state_d inside {ST_FIRE, ST_WAIT_ACK};
      armed_q    <= (state_d == ST_ARMED);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fire_cnt_q <= '0;
      miss_cnt_q <= '0;
      ack_to_q   <= 1'b0;
    end else if (ClearStatus) begin
      fire_cnt_q <= '0;
      miss_cnt_q <= '0;
      ack_to_q   <= 1'b0;
    end else begin
      if (fire_now)                     fire_cnt_q <= fire_cnt_q + 16'd1;
      if (miss_now && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 8'd1;
      if (set_timeout)                  ack_to_q   <= 1'b1;
    end
  end

  assign IlaTrigger = trig_q;
  assign Armed      = armed_q;
  assign FireCount  = fire_cnt_q;
  assign MissCount  = miss_cnt_q;
  assign AckTimeout = ack_to_q;

endmodule
